// File: rtl/bram_result_reader.sv
// Read-back engine: drains words 0..len-1 from BRAM1 port B onto a valid/ready stream.
// Optional macro BRAM_READER_CHKSUM_EN adds chksum_o, the running sum of transferred beats.
module bram_result_reader #(
    parameter int CNT_BIT   = 31,
    parameter int DWIDTH    = 64,
    parameter int AWIDTH    = 8,
    parameter int MEM_SIZE  = 256,
    parameter int BUF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_run_i,
    input  logic [CNT_BIT-1:0] run_count_i,
    output logic               idle_o,
    output logic               read_o,
    output logic               done_o,
    output logic [AWIDTH-1:0]  addr_b1_o,
    output logic               ce_b1_o,
    output logic               we_b1_o,
    input  logic [DWIDTH-1:0]  q_b1_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [DWIDTH-1:0]  m_data_o,
    output logic               m_last_o
`ifdef BRAM_READER_CHKSUM_EN
    ,
    output logic [DWIDTH-1:0]  chksum_o
`endif
);

    localparam int CW = $clog2(MEM_SIZE + 1);
    localparam int PW = $clog2(BUF_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [CW-1:0]     len_r;
    logic [CW-1:0]     len_s;
    logic [CW-1:0]     issue_cnt_r;
    logic [CW-1:0]     beat_cnt_r;
    logic              ce_r;
    logic [AWIDTH-1:0] addr_r;
    logic              rd_vld_r;
    logic              idle_r;
    logic              read_r;
    logic              done_r;

    logic [DWIDTH-1:0] fifo_mem_r [BUF_DEPTH];
    logic [PW-1:0]     fifo_wr_ptr_r;
    logic [PW-1:0]     fifo_rd_ptr_r;
    logic [PW:0]       fifo_cnt_r;

    logic              m_valid_r;
    logic [DWIDTH-1:0] m_data_r;
    logic              m_last_r;

    logic              start_acc_s;
    logic              pop_s;
    logic              load_out_s;
    logic              fifo_empty_s;
    logic              bypass_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic [CW-1:0]     head_idx_s;
    logic              head_last_s;
    logic [PW+1:0]     credit_s;
    logic              issue_s;

    // Run length clamp: anything beyond the memory depth reads the whole memory once.
    always_comb begin
        if (run_count_i > CNT_BIT'(MEM_SIZE)) begin
            len_s = CW'(MEM_SIZE);
        end else begin
            len_s = run_count_i[CW-1:0];
        end
    end

    // Handshake, buffer steering and read-credit decode.
    always_comb begin
        start_acc_s  = (state_r == ST_IDLE) && start_run_i;
        pop_s        = m_valid_r && m_ready_i;
        load_out_s   = !m_valid_r || pop_s;
        fifo_empty_s = (fifo_cnt_r == (PW+1)'(0));
        bypass_s     = load_out_s && fifo_empty_s && rd_vld_r;
        fifo_push_s  = rd_vld_r && !bypass_s;
        fifo_pop_s   = load_out_s && !fifo_empty_s;
        head_idx_s   = beat_cnt_r + CW'(pop_s);
        head_last_s  = (head_idx_s == (len_r - CW'(1)));
        // Credit counts every word already owed to the buffer, including both pipeline stages.
        credit_s     = (PW+2)'(fifo_cnt_r) + (PW+2)'(m_valid_r) + (PW+2)'(ce_r) + (PW+2)'(rd_vld_r);
        issue_s      = (state_r == ST_RUN) && (issue_cnt_r < len_r) && (credit_s < (PW+2)'(BUF_DEPTH));
    end

    // Next-state decode for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_s = (len_s == CW'(0)) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && m_last_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, status flags, run counters and the BRAM read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            len_r       <= CW'(0);
            issue_cnt_r <= CW'(0);
            beat_cnt_r  <= CW'(0);
            ce_r        <= 1'b0;
            addr_r      <= AWIDTH'(0);
            rd_vld_r    <= 1'b0;
            idle_r      <= 1'b1;
            read_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r  <= state_s;
            idle_r   <= (state_s == ST_IDLE);
            read_r   <= (state_s == ST_RUN);
            done_r   <= (state_s == ST_DONE);
            rd_vld_r <= ce_r;
            if (start_acc_s) begin
                len_r      <= len_s;
                beat_cnt_r <= CW'(0);
                addr_r     <= AWIDTH'(0);
                // The first read leaves in the cycle right after the start edge.
                if (len_s != CW'(0)) begin
                    ce_r        <= 1'b1;
                    issue_cnt_r <= CW'(1);
                end else begin
                    ce_r        <= 1'b0;
                    issue_cnt_r <= CW'(0);
                end
            end else begin
                if (issue_s) begin
                    ce_r        <= 1'b1;
                    addr_r      <= issue_cnt_r[AWIDTH-1:0];
                    issue_cnt_r <= issue_cnt_r + CW'(1);
                end else begin
                    ce_r <= 1'b0;
                end
                if (pop_s) begin
                    beat_cnt_r <= beat_cnt_r + CW'(1);
                end
            end
        end
    end

    // Buffer storage; contents are don't-care whenever the count says empty.
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            fifo_mem_r[fifo_wr_ptr_r] <= q_b1_i;
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_wr_ptr_r <= PW'(0);
            fifo_rd_ptr_r <= PW'(0);
            fifo_cnt_r    <= (PW+1)'(0);
        end else begin
            if (fifo_push_s) begin
                fifo_wr_ptr_r <= fifo_wr_ptr_r + PW'(1);
            end
            if (fifo_pop_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + PW'(1);
            end
            fifo_cnt_r <= fifo_cnt_r + (PW+1)'(fifo_push_s) - (PW+1)'(fifo_pop_s);
        end
    end

    // Output head register; refilled from the buffer, or straight from BRAM when the buffer is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_data_r  <= DWIDTH'(0);
            m_last_r  <= 1'b0;
        end else if (load_out_s) begin
            if (fifo_pop_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= fifo_mem_r[fifo_rd_ptr_r];
                m_last_r  <= head_last_s;
            end else if (rd_vld_r) begin
                m_valid_r <= 1'b1;
                m_data_r  <= q_b1_i;
                m_last_r  <= head_last_s;
            end else begin
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
            end
        end
    end

`ifdef BRAM_READER_CHKSUM_EN
    logic [DWIDTH-1:0] chksum_r;

    // Running modulo-2^DWIDTH sum of accepted beats, held after the run ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            chksum_r <= DWIDTH'(0);
        end else if (start_acc_s) begin
            chksum_r <= DWIDTH'(0);
        end else if (pop_s) begin
            chksum_r <= chksum_r + m_data_r;
        end
    end

    assign chksum_o = chksum_r;
`endif

    assign idle_o    = idle_r;
    assign read_o    = read_r;
    assign done_o    = done_r;
    assign addr_b1_o = addr_r;
    assign ce_b1_o   = ce_r;
    assign we_b1_o   = 1'b0;
    assign m_valid_o = m_valid_r;
    assign m_data_o  = m_data_r;
    assign m_last_o  = m_last_r;

endmodule

// File: tb/tb_bram_result_reader.sv
// Scoreboard bench for bram_result_reader: BRAM model returns addr+1, monitor pops expected beats.
module tb_bram_result_reader;

    logic        clk;
    logic        reset;
    logic        start_run_i;
    logic [30:0] run_count_i;
    logic        idle_o;
    logic        read_o;
    logic        done_o;
    logic [7:0]  addr_b1_o;
    logic        ce_b1_o;
    logic        we_b1_o;
    logic [63:0] q_b1_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [63:0] m_data_o;
    logic        m_last_o;
`ifdef BRAM_READER_CHKSUM_EN
    logic [63:0] chksum_o;
`endif

    bram_result_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start_run_i (start_run_i),
        .run_count_i (run_count_i),
        .idle_o      (idle_o),
        .read_o      (read_o),
        .done_o      (done_o),
        .addr_b1_o   (addr_b1_o),
        .ce_b1_o     (ce_b1_o),
        .we_b1_o     (we_b1_o),
        .q_b1_i      (q_b1_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o)
`ifdef BRAM_READER_CHKSUM_EN
        ,
        .chksum_o    (chksum_o)
`endif
    );

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } beat_t;

    beat_t       exp_q [$];
    int          checks     = 0;
    int          failures   = 0;
    int          run_beats  = 0;
    int          run_issued = 0;
    int          issued     = 0;
    int          xfers      = 0;
    int          last_addr  = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = 64'd0;
    logic        prev_last  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle-latency BRAM model whose word at address a holds a+1.
    always @(posedge clk) begin
        if (ce_b1_o) q_b1_i <= 64'(addr_b1_o) + 64'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: credit and address order on issue, scoreboard on transfer, stability on stall.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            issued = xfers;
        end else begin
            if (ce_b1_o) begin
                issued++;
                run_issued++;
                last_addr = int'(addr_b1_o);
                check("addr_order", 64'(addr_b1_o), 64'(run_issued - 1));
                check("credit", 64'(issued - xfers <= 4), 64'd1);
            end
            if (prev_stall) begin
                check("stall_valid", 64'(m_valid_o), 64'd1);
                check("stall_data", m_data_o, prev_data);
                check("stall_last", 64'(m_last_o), 64'(prev_last));
            end
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h expected=none", m_data_o);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", m_data_o, e.data);
                    check("beat_last", 64'(m_last_o), 64'(e.last));
                end
                run_beats++;
                xfers++;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
        end
    end

    // Queue the expected beats, then present start for one edge (E0); returns at E0+1.
    task automatic start_run(input int cnt, input bit expect_beats);
        int n;
        n = (cnt > 256) ? 256 : cnt;
        @(posedge clk);
        #1;
        if (expect_beats) begin
            for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), 64'(k + 1)});
            run_beats  = 0;
            run_issued = 0;
        end
        start_run_i = 1'b1;
        run_count_i = 31'(cnt);
        @(posedge clk);
        #1;
        start_run_i = 1'b0;
    endtask

    // Step cycles driving m_ready_i (mode 0: always 1, mode 1: toggle with a 10-cycle stall) until done_o.
    task automatic run_until_done(input int max_cycles, input int mode, input string name);
        bit got;
        got = 1'b0;
        for (int n = 0; n < max_cycles && !got; n++) begin
            @(posedge clk);
            #1;
            if (mode == 0) m_ready_i = 1'b1;
            else m_ready_i = (n >= 20 && n < 30) ? 1'b0 : ((n % 2) == 0);
            @(negedge clk);
            if (done_o) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done expected=done_o", name);
        end
        #1;
        m_ready_i = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        start_run_i = 1'b0;
        run_count_i = 31'd0;
        m_ready_i   = 1'b1;
        q_b1_i      = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_read", 64'(read_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_ce", 64'(ce_b1_o), 64'd0);
        check("rst_we", 64'(we_b1_o), 64'd0);
        check("rst_addr", 64'(addr_b1_o), 64'd0);
        check("rst_valid", 64'(m_valid_o), 64'd0);
        check("rst_last", 64'(m_last_o), 64'd0);
        reset = 1'b0;

        // Count 4, ready held high: latency and back-to-back beats.
        start_run(4, 1'b1);
        @(negedge clk);
        check("t1_ce_first", 64'(ce_b1_o), 64'd1);
        check("t1_read", 64'(read_o), 64'd1);
        check("t1_idle", 64'(idle_o), 64'd0);
        check("t1_valid_e0", 64'(m_valid_o), 64'd0);
        @(negedge clk);
        check("t1_valid_e1", 64'(m_valid_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid_run", 64'(m_valid_o), 64'd1);
            check("t1_last_flag", 64'(m_last_o), 64'(i == 3));
        end
        @(negedge clk);
        check("t1_done", 64'(done_o), 64'd1);
        check("t1_done_idle", 64'(idle_o), 64'd0);
        check("t1_done_read", 64'(read_o), 64'd0);
        check("t1_done_valid", 64'(m_valid_o), 64'd0);
`ifdef BRAM_READER_CHKSUM_EN
        check("t1_chksum", chksum_o, 64'd10);
`endif
        @(negedge clk);
        check("t1_done_pulse", 64'(done_o), 64'd0);
        check("t1_idle_after", 64'(idle_o), 64'd1);
        check("t1_beats", 64'(run_beats), 64'd4);

        // Count 16 with toggling ready and a long stall.
        start_run(16, 1'b1);
        run_until_done(200, 1, "t2");
        check("t2_beats", 64'(run_beats), 64'd16);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // Count 0: immediate done, no reads, no beats.
        start_run(0, 1'b1);
        @(negedge clk);
        check("t3_done", 64'(done_o), 64'd1);
        check("t3_ce", 64'(ce_b1_o), 64'd0);
        check("t3_valid", 64'(m_valid_o), 64'd0);
        @(negedge clk);
        check("t3_idle", 64'(idle_o), 64'd1);
        check("t3_issued", 64'(run_issued), 64'd0);
        check("t3_beats", 64'(run_beats), 64'd0);

        // Count 300 clamps to the full memory.
        start_run(300, 1'b1);
        run_until_done(400, 0, "t4");
        check("t4_beats", 64'(run_beats), 64'd256);
        check("t4_issued", 64'(run_issued), 64'd256);
        check("t4_last_addr", 64'(last_addr), 64'd255);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Start re-pulsed mid-run is ignored.
        start_run(8, 1'b1);
        start_run(2, 1'b0);
        run_until_done(100, 0, "t5");
        check("t5_beats", 64'(run_beats), 64'd8);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset after beat 3 of 8, then a fresh count-2 run.
        start_run(8, 1'b1);
        for (int n = 0; n < 50 && run_beats < 3; n++) begin
            @(posedge clk);
            #1;
        end
        check("t6_reached_beat3", 64'(run_beats), 64'd3);
        reset     = 1'b1;
        m_ready_i = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        m_ready_i = 1'b1;
        @(negedge clk);
        check("t6_valid", 64'(m_valid_o), 64'd0);
        check("t6_idle", 64'(idle_o), 64'd1);
        check("t6_done", 64'(done_o), 64'd0);
        @(negedge clk);
        check("t6_no_done", 64'(done_o), 64'd0);
        check("t6_no_valid", 64'(m_valid_o), 64'd0);
        start_run(2, 1'b1);
        run_until_done(50, 0, "t6b");
        check("t6_beats", 64'(run_beats), 64'd2);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
